// File: rtl/fmul_arb.sv
// Round-robin arbiter sharing one Q8.8 signed multiplier among N_REQ requesters.
// Optional macro FMUL_ARB_SAT_EN selects saturating instead of wrapping results.
module fmul_arb #(
    parameter int N_REQ = 4,
    parameter int BITS  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*BITS-1:0]   req_a,
    input  logic [N_REQ*BITS-1:0]   req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [BITS-1:0]         rsp_p,
    output logic                    busy
);

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PBITS = 2 * BITS;

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           grant_idx;
    logic [PW-1:0]           scan_idx;
    logic [PW:0]             scan_sum;
    logic                    grant_any;
    logic [PW-1:0]           next_ptr;
    logic [BITS-1:0]         sel_a;
    logic [BITS-1:0]         sel_b;

    logic                    s1_valid;
    logic signed [BITS-1:0]  s1_a;
    logic signed [BITS-1:0]  s1_b;
    logic [PW-1:0]           s1_tag;
    logic                    s2_valid;
    logic signed [PBITS-1:0] s2_prod;
    logic [PW-1:0]           s2_tag;
    logic [BITS-1:0]         prod_q;

    // Scan upward from rr_ptr, wrapping modulo N_REQ; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(N_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (RST) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign next_ptr = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_a    = req_a[grant_idx*BITS +: BITS];
    assign sel_b    = req_b[grant_idx*BITS +: BITS];

`ifdef FMUL_ARB_SAT_EN
    logic prod_ovf;
    logic unused_prod_lo;

    // The result fits only when every bit above the kept field matches the sign.
    assign prod_ovf = (s2_prod[PBITS-1:BITS+7] != {(BITS-7){s2_prod[PBITS-1]}});
    assign prod_q   = !prod_ovf          ? s2_prod[BITS+7:8] :
                      s2_prod[PBITS-1]   ? {1'b1, {(BITS-1){1'b0}}} :
                                           {1'b0, {(BITS-1){1'b1}}};
    assign unused_prod_lo = ^s2_prod[7:0];
`else
    logic unused_prod_bits;

    assign prod_q = s2_prod[BITS+7:8];
    assign unused_prod_bits = ^{s2_prod[PBITS-1:BITS+8], s2_prod[7:0]};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_tag    <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            s1_valid <= grant_any;
            if (grant_any) begin
                rr_ptr <= next_ptr;
                s1_a   <= sel_a;
                s1_b   <= sel_b;
                s1_tag <= grant_idx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= s1_a * s1_b;
                s2_tag  <= s1_tag;
            end
            rsp_valid <= '0;
            if (s2_valid) begin
                rsp_valid[s2_tag] <= 1'b1;
                rsp_p             <= prod_q;
            end
        end
    end

    assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_fmul_arb.sv
// Bench for fmul_arb: queue-based arbitration/product model compared every cycle,
// plus directed vectors with literal expectations. Honours FMUL_ARB_SAT_EN.
module tb_fmul_arb;
    localparam int N = 4;
    localparam int W = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_p;
    logic           busy;

    always #5 CLK = ~CLK;

    fmul_arb #(.N_REQ(N), .BITS(W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fx_model(input logic [15:0] a, input logic [15:0] b);
        longint pr;
        longint sh;
        pr = longint'($signed(a)) * longint'($signed(b));
        sh = pr >>> 8;
`ifdef FMUL_ARB_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`endif
        return sh[15:0];
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int          tag;
        logic [15:0] p;
        int          due;
    } ent_t;

    ent_t        q[$];
    int          cyc    = 0;
    int          rr     = 0;
    logic [15:0] last_p = '0;

    // Model: each accept is queued with the cycle its response must appear.
    always @(posedge CLK or posedge RST) begin
        int   g;
        ent_t e;
        if (RST) begin
            q.delete();
            rr     = 0;
            cyc    = 0;
            last_p = '0;
        end else begin
            cyc++;
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            g = pick(req_valid, rr);
            if (g >= 0) begin
                e.tag = g;
                e.p   = fx_model(req_a[g*W +: W], req_b[g*W +: W]);
                e.due = cyc + 2;
                q.push_back(e);
                rr = (g + 1) % N;
            end
            if (q.size() > 0 && q[0].due == cyc) last_p = q[0].p;
        end
    end

    always @(negedge CLK) begin
        logic [N-1:0] er;
        logic [N-1:0] ev;
        logic         eb;
        int           g;
        er = '0;
        ev = '0;
        eb = 1'b0;
        if (!RST) begin
            g = pick(req_valid, rr);
            if (g >= 0) er[g] = 1'b1;
            foreach (q[i]) begin
                if (q[i].due == cyc) ev[q[i].tag] = 1'b1;
                if (q[i].due > cyc) eb = 1'b1;
            end
        end
        check("cmp_ready", 32'(req_ready), 32'(er));
        check("cmp_rsp_valid", 32'(rsp_valid), 32'(ev));
        check("cmp_busy", 32'(busy), 32'(eb));
        check("cmp_rsp_p", 32'(rsp_p), 32'(last_p));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    int          vr[6] = '{0, 2, 3, 1, 1, 0};
    logic [15:0] va[6] = '{16'h0100, 16'h0280, 16'hFF80, 16'h0001, 16'hFFFF, 16'h0180};
    logic [15:0] vb[6] = '{16'h0100, 16'hFE80, 16'hFE00, 16'h0001, 16'h0001, 16'h0300};
    logic [15:0] vp[6] = '{16'h0100, 16'hFC40, 16'h0100, 16'h0000, 16'hFFFF, 16'h0480};

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] ovf_exp;
`ifdef FMUL_ARB_SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'hFE00;
`endif
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_p", 32'(rsp_p), 32'd0);
        req_valid = '1;
        #1 check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        RST = 1'b0;

        // 1.0 * 1.0 on requester 0
        put(0, 16'h0100, 16'h0100);
        req_valid = 4'b0001;
        #1 check("one_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("one_busy", 32'(busy), 32'd1);
        tick();
        check("one_rv_early", 32'(rsp_valid), 32'd0);
        tick();
        check("one_rv", 32'(rsp_valid), 32'h1);
        check("one_p", 32'(rsp_p), 32'h0100);
        tick();
        check("one_hold_rv", 32'(rsp_valid), 32'd0);
        check("one_hold_p", 32'(rsp_p), 32'h0100);
        check("one_idle_busy", 32'(busy), 32'd0);

        // 2.5 * -1.5 on requester 2
        put(2, 16'h0280, 16'hFE80);
        req_valid = 4'b0100;
        #1 check("neg_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("neg_rv", 32'(rsp_valid), 32'h4);
        check("neg_p", 32'(rsp_p), 32'hFC40);

        // 127 * 2 overflow on requester 1; rr_ptr=3 so the scan wraps
        put(1, 16'h7F00, 16'h0200);
        req_valid = 4'b0010;
        #1 check("ovf_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("ovf_rv", 32'(rsp_valid), 32'h2);
        check("ovf_p", 32'(rsp_p), 32'(ovf_exp));

        // rr_ptr=2 with requesters 1 and 3 pending
        put(1, 16'h0100, 16'h0300);
        put(3, 16'h0200, 16'h0200);
        req_valid = 4'b1010;
        #1 check("rr_first", 32'(req_ready), 32'h8);
        tick();
        check("rr_second", 32'(req_ready), 32'h2);
        tick();
        put(0, 16'h0100, 16'h0100);
        put(2, 16'h0100, 16'h0100);
        req_valid = 4'b1111;
        #1 check("rr_end_ptr", 32'(req_ready), 32'h4);
        req_valid = '0;
        tick();
        check("rr_rv3", 32'(rsp_valid), 32'h8);
        check("rr_p3", 32'(rsp_p), 32'h0400);
        tick();
        check("rr_rv1", 32'(rsp_valid), 32'h2);
        check("rr_p1", 32'(rsp_p), 32'h0300);

        // Back-to-back single-requester vectors
        for (int j = 0; j < 9; j++) begin
            req_valid = '0;
            if (j < 6) begin
                put(vr[j], va[j], vb[j]);
                req_valid[vr[j]] = 1'b1;
                #1 check("tbl_ready", 32'(req_ready), 32'(4'b0001 << vr[j]));
            end
            if (j >= 3) begin
                check("tbl_rv", 32'(rsp_valid), 32'(4'b0001 << vr[j-3]));
                check("tbl_p", 32'(rsp_p), 32'(vp[j-3]));
            end
            tick();
        end

        // All four held valid from reset release
        RST = 1'b1;
        for (int r = 0; r < N; r++) put(r, 16'(16'h0100 * (r + 1)), 16'h0080);
        req_valid = 4'b1111;
        tick();
        check("all_rst_ready", 32'(req_ready), 32'd0);
        RST = 1'b0;
        for (int j = 0; j < 10; j++) begin
            #1 check("all_ready", 32'(req_ready), 32'(4'b0001 << (j % 4)));
            if (j >= 3) check("all_rv", 32'(rsp_valid), 32'(4'b0001 << ((j - 3) % 4)));
            tick();
        end

        // Reset mid-operation discards in-flight work
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        RST = 1'b1;
        #1 check("mid_busy", 32'(busy), 32'd0);
        check("mid_rv", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("post_rv", 32'(rsp_valid), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
        end
        req_valid = 4'b1111;
        #1 check("post_ptr", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
